// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register slice: widths, the
// bubble destination, the EX-side register bundle and the per-edge action.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 3;

    // Register 0 is reserved as the bubble destination so that a bubble
    // can never be mistaken for a forwarding source.
    localparam logic [REG_W-1:0] BUBBLE_DEST = 4'd0;

    // Everything EX needs from one decoded instruction.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic              is_load;
        logic [REG_W-1:0]  r2;
        logic [REG_W-1:0]  r3;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] r2_val;
        logic [DATA_W-1:0] r3_val;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    // What the EX register does at the next clock edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } ex_action_e;

    // A bubble: not valid, never writes, never a load, parked on BUBBLE_DEST.
    function automatic id_ex_t make_bubble();
        id_ex_t b;
        b      = '0;
        b.dest = BUBBLE_DEST;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decode front end and the ID/EX register: decoded ID
// fields and pipeline controls in, registered EX fields and stall out.
interface id_ex_stage_if;
    import pipe_pkg::*;

    logic              id_valid;
    logic [REG_W-1:0]  id_r2;
    logic [REG_W-1:0]  id_r3;
    logic              id_r2_used;
    logic              id_r3_used;
    logic [DATA_W-1:0] id_r2_val;
    logic [DATA_W-1:0] id_r3_val;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_dest;
    logic              id_we;
    logic              id_is_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              mem_hold;

    logic              ex_valid;
    logic              ex_we;
    logic              ex_is_load;
    logic [REG_W-1:0]  ex_r2;
    logic [REG_W-1:0]  ex_r3;
    logic [REG_W-1:0]  ex_dest;
    logic [DATA_W-1:0] ex_r2_val;
    logic [DATA_W-1:0] ex_r3_val;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall;

    // Front end side: supplies ID fields and controls, observes EX and stall.
    modport master (
        output id_valid, id_r2, id_r3, id_r2_used, id_r3_used,
               id_r2_val, id_r3_val, id_imm, id_dest, id_we, id_is_load,
               id_ctrl, flush, mem_hold,
        input  ex_valid, ex_we, ex_is_load, ex_r2, ex_r3, ex_dest,
               ex_r2_val, ex_r3_val, ex_imm, ex_ctrl, stall
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_r2, id_r3, id_r2_used, id_r3_used,
               id_r2_val, id_r3_val, id_imm, id_dest, id_we, id_is_load,
               id_ctrl, flush, mem_hold,
        output ex_valid, ex_we, ex_is_load, ex_r2, ex_r3, ex_dest,
               ex_r2_val, ex_r3_val, ex_imm, ex_ctrl, stall
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: the ID instruction reads a register that the
// load currently in EX has not yet produced.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_r2,
    input  logic [REG_W-1:0] id_r3,
    input  logic             id_r2_used,
    input  logic             id_r3_used,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_dest,
    output logic             haz
);

    logic r2_hit;
    logic r3_hit;
    logic ex_pending_load;

    // A hit on either source (or both) is one hazard; unused sources never match.
    always_comb begin
        r2_hit          = id_r2_used & (id_r2 == ex_dest);
        r3_hit          = id_r3_used & (id_r3 == ex_dest);
        ex_pending_load = ex_valid & ex_is_load & ex_we;
        haz             = id_valid & ex_pending_load & (r2_hit | r3_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decoded operands and control into EX,
// inserts LOAD_LAT bubbles on a load-use hazard while stalling the front
// end, and obeys branch flush and memory hold.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_LAT - 1);

    id_ex_t           ex_q;
    id_ex_t           id_in;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    ex_action_e       action;
    logic             haz_raw;
    logic             haz;
    logic             cnt_busy;

    load_use_detect u_detect (
        .id_valid   (bus.id_valid),
        .id_r2      (bus.id_r2),
        .id_r3      (bus.id_r3),
        .id_r2_used (bus.id_r2_used),
        .id_r3_used (bus.id_r3_used),
        .ex_valid   (ex_q.valid),
        .ex_we      (ex_q.we),
        .ex_is_load (ex_q.is_load),
        .ex_dest    (ex_q.dest),
        .haz        (haz_raw)
    );

    // Gather the ID fields into the same bundle layout as the EX register.
    always_comb begin
        id_in         = '0;
        id_in.valid   = bus.id_valid;
        id_in.we      = bus.id_we;
        id_in.is_load = bus.id_is_load;
        id_in.r2      = bus.id_r2;
        id_in.r3      = bus.id_r3;
        id_in.dest    = bus.id_dest;
        id_in.r2_val  = bus.id_r2_val;
        id_in.r3_val  = bus.id_r3_val;
        id_in.imm     = bus.id_imm;
        id_in.ctrl    = bus.id_ctrl;
    end

    // Edge priority: flush, then memory hold, then an ongoing bubble run,
    // then a fresh hazard, otherwise a normal load.
    always_comb begin
        cnt_busy = (cnt_q != '0);
        haz      = haz_raw & ~cnt_busy;
        action   = ACT_LOAD;
        cnt_d    = cnt_q;
        if (bus.flush) begin
            action = ACT_BUBBLE;
            cnt_d  = '0;
        end else if (bus.mem_hold) begin
            action = ACT_HOLD;
        end else if (cnt_busy) begin
            action = ACT_BUBBLE;
            cnt_d  = cnt_q - 3'd1;
        end else if (haz) begin
            action = ACT_BUBBLE;
            cnt_d  = CNT_RELOAD;
        end
        bus.stall = ~bus.flush & (bus.mem_hold | cnt_busy | haz);
    end

    // EX register and remaining-bubble counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= make_bubble();
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (action)
                ACT_LOAD:   ex_q <= id_in;
                ACT_BUBBLE: ex_q <= make_bubble();
                default:    ex_q <= ex_q;
            endcase
        end
    end

    // Registered EX view for the forwarding unit and the ALU.
    always_comb begin
        bus.ex_valid   = ex_q.valid;
        bus.ex_we      = ex_q.we;
        bus.ex_is_load = ex_q.is_load;
        bus.ex_r2      = ex_q.r2;
        bus.ex_r3      = ex_q.r3;
        bus.ex_dest    = ex_q.dest;
        bus.ex_r2_val  = ex_q.r2_val;
        bus.ex_r3_val  = ex_q.r3_val;
        bus.ex_imm     = ex_q.imm;
        bus.ex_ctrl    = ex_q.ctrl;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute pipeline register with load-use hazard detection.
- Sits between register-file read (ID) and the ALU operand forwarding unit (EX).
- Registers decoded operands, register indices, destination and control into EX.
- Inserts bubbles and stalls the front end on load-use hazards; honours branch flush and memory hold.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 4, register index width
- CTRL_W, 8, opaque ALU/mem control bundle width
- LOAD_LAT, 1, bubbles required between a load in EX and a dependent consumer (1..7)
- BUBBLE_DEST, 4'd0, destination index driven for a bubble

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_r2, id_r3  in  REG_W  source register indices
- id_r2_used, id_r3_used  in  1  source actually read
- id_r2_val, id_r3_val  in  DATA_W  register-file read data
- id_imm  in  DATA_W  immediate
- id_dest  in  REG_W  destination index
- id_we  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- id_ctrl  in  CTRL_W  control bundle
- flush  in  1  branch taken in EX; kill the ID instruction
- mem_hold  in  1  memory stage busy; freeze pipeline
- ex_valid, ex_we, ex_is_load  out  1  registered copies
- ex_r2, ex_r3, ex_dest  out  REG_W  registered indices (feed forwarding unit)
- ex_r2_val, ex_r3_val, ex_imm  out  DATA_W  registered data
- ex_ctrl  out  CTRL_W  registered control
- stall  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs 0 except ex_dest=BUBBLE_DEST; bubble counter cnt=0. Reset is checked every cycle and aborts any stall sequence.
- Bubble: ex_valid=0, ex_we=0, ex_is_load=0, ex_dest=BUBBLE_DEST, ex_ctrl=0. Index and data fields are 0.
- Hazard (combinational, evaluated only when cnt==0):
  - haz = id_valid & ex_valid & ex_is_load & ex_we & ((id_r2_used & id_r2==ex_dest) | (id_r3_used & id_r3==ex_dest)).
- Per-edge priority: rst > flush > mem_hold > stall sequence > normal load.
  - flush: EX loads a bubble, cnt=0. stall=0 during flush.
  - mem_hold (no flush): every EX register and cnt hold their values. stall=1.
  - cnt==0 and haz: EX loads a bubble, cnt=LOAD_LAT-1. stall=1.
  - cnt>0: EX loads a bubble, cnt decrements. stall=1.
  - Otherwise: EX loads all id_* fields (ex_valid=id_valid). stall=0.
- stall = ~flush & (mem_hold | (cnt!=0) | haz).
- Latency:
  - Single-cycle register: ID fields appear on ex_* one edge after capture.
  - A load-use pair incurs exactly LOAD_LAT bubble cycles. The dependent instruction enters EX on edge LOAD_LAT+1 after the load entered EX.
- Boundary cases:
  - Hazard on both sources counts once.
  - id_valid=0 never raises haz.
  - A source with used=0 never matches.
  - mem_hold during a stall sequence freezes cnt; the remaining bubble count is preserved.
  - flush during a stall sequence cancels it.
  - Back-to-back loads with a dependency are treated as an ordinary load-use.
- Bubble contract: EX writers are identified by ex_we, and a bubble never holds ex_we=1. The forwarding unit compares only against ex_dest, so the BUBBLE_DEST register must not be a forwarding source. Register 0 is reserved for that purpose.
- cnt width: 3 bits.

Decomposition:
- Shared package pipe_pkg:
  - REG_W, DATA_W, CTRL_W constants
  - BUBBLE_DEST constant
  - packed struct id_ex_t {valid, we, is_load, r2, r3, dest, r2_val, r3_val, imm, ctrl}
  - function make_bubble() returning id_ex_t
- Sub-module load_use_detect: combinational haz from ID sources and EX fields.
- The register, counter and priority logic stay in id_ex_stage.

Test Plan:
- Reset mid-stall: LOAD_LAT=2, hazard raised, rst after 1 bubble -> next cycle cnt=0, ex_valid=0, ex_dest=0, stall=0.
- Normal flow: id_r2=3, id_r2_val=32'h1234_5678, id_dest=5, id_we=1, no hazard -> next cycle ex_r2=3, ex_r2_val=32'h12345678, ex_dest=5, stall=0.
- Load-use, LOAD_LAT=1: EX holds load dest=4; ID add r3=4 used -> stall=1 for 1 cycle, ex bubble (ex_dest=0, ex_we=0); following edge ex_r3=4, ex_valid=1.
- LOAD_LAT=3 with mem_hold asserted 2 cycles after the first bubble -> stall stays 1 for 3+2=5 cycles total; exactly 3 bubbles reach EX.
- Flush during stall: hazard stalling, flush=1 -> ex bubble, stall=0 that cycle, cnt=0; next ID instruction loads normally.
- No false hazard: EX load dest=6 with id_r2=6 but id_r2_used=0 -> stall=0. EX non-load dest=6 with id_r2_used=1 -> stall=0.
